tick_phase_sequencer: RTL and testbench
=======================================

Name: tick_phase_sequencer

Overview:
- Downstream consumer of the divide-by-3 prescaler's one-cycle `tick` pulse.
- Sequences a two-road traffic-light controller: north-south (NS) and east-west (EW) phases, with all-red clearance and an optional pedestrian walk phase.
- Each phase lasts a parameterised number of ticks.
- Drives one-hot lamp outputs plus a state/phase-done status.

Parameters:
- GREEN_TICKS, 5, ticks spent in each green phase (>=1)
- YELLOW_TICKS, 2, ticks spent in each yellow phase (>=1)
- ALLRED_TICKS, 1, ticks spent in each all-red clearance phase (>=1)
- WALK_TICKS, 3, ticks spent in the pedestrian walk phase (>=1)
- CNT_W, 4, tick-counter width; must hold max(*_TICKS)-1

Ports:
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high reset
- tick  in  1  one-clk-wide advance pulse from the upstream prescaler
- ped_req  in  1  pedestrian request, level, sampled every clk
- ns_light  out  3  NS lamp {R,Y,G}, one-hot
- ew_light  out  3  EW lamp {R,Y,G}, one-hot
- walk  out  1  pedestrian walk lamp
- state  out  3  current state encoding
- phase_done  out  1  one-clk pulse on the first cycle of each new state

Behaviour:
- Clock and reset: one clock, `clk`. Reset is asynchronous and active-high on `reset`. All registers update on posedge clk or posedge reset.
- State encoding:
  - NS_GREEN=0, NS_YELLOW=1, ALLRED_A=2
  - EW_GREEN=3, EW_YELLOW=4, ALLRED_B=5
  - PED_WALK=6
  - 7 is illegal.
- Reset values (also apply on reset mid-phase; no partial state survives):
  - state=ALLRED_B, cnt=0, ped_pend=0, phase_done=0
  - ns_light=ew_light=3'b100, walk=0
- Tick counter `cnt`:
  - Cycles with tick=0 hold cnt and state.
  - On tick=1: if cnt==DUR(state)-1, advance state and set cnt=0; otherwise cnt=cnt+1.
  - DUR=1 means the state advances on its first tick.
- Transitions, each taken only on the terminal tick:
  - NS_GREEN -> NS_YELLOW -> ALLRED_A -> EW_GREEN -> EW_YELLOW -> ALLRED_B.
  - ALLRED_B -> PED_WALK if ped_pend=1 (feature enabled), else NS_GREEN.
  - PED_WALK -> NS_GREEN.
- Illegal state 7: next clk forces ALLRED_A, cnt=0, no tick required.
- Lamp decode (Moore, combinational from registered state; no glitch-sensitive consumers):
  - NS_GREEN: ns=001, ew=100
  - NS_YELLOW: ns=010, ew=100
  - EW_GREEN: ns=100, ew=001
  - EW_YELLOW: ns=100, ew=010
  - ALLRED_A/B, PED_WALK, illegal: ns=ew=100
  - walk=1 only in PED_WALK.
  - At no time are both roads non-red.
- phase_done: registered. It is 1 exactly in the first clk where `state` shows the new value after a transition. It is 0 after reset and after illegal-state recovery.
- Pedestrian latch `ped_pend`:
  - Set on any clk with ped_req=1, except while in PED_WALK.
  - Cleared on the clk that enters PED_WALK.
  - ped_req=1 on that same entry clk is consumed (pend ends 0).
  - Multiple requests before service collapse into one walk.
- tick asserted for more than one clk: each high cycle counts as one tick. The upstream contract is that this never happens; no checking is done.
- Timing with defaults, no pedestrian: full cycle = 5+2+1+5+2+1 = 16 ticks. From reset, the first NS_GREEN is entered on the 1st tick.

Optional Feature:
- Macro: TICK_PHASE_PED_WALK_EN.
- Defined:
  - ped_pend latch and PED_WALK state are built as described.
  - walk is driven from state.
- Undefined:
  - ped_req is ignored (port kept, unconnected internally) and ped_pend is not built.
  - walk is tied 0.
  - ALLRED_B always -> NS_GREEN.
  - Encoding 6 is treated as illegal (recovers to ALLRED_A).

Test Plan:
- Reset, then tick every 3rd clk, ped_req=0, for 17 ticks:
  - states step 5,0(x5 ticks),1(x2),2(x1),3(x5),4(x2),5(x1),0.
  - phase_done pulses once per change (7 pulses).
  - ns_light/ew_light never both != 100.
- tick held 0 for 50 clks in NS_GREEN -> state and cnt unchanged, phase_done=0 throughout.
- Feature on: ped_req pulsed 1 clk during EW_GREEN ->
  - after ALLRED_B, state=6, walk=1 for 3 ticks.
  - then state=0, walk=0.
  - a second request during PED_WALK is not latched.
- Feature off: same stimulus -> ALLRED_B goes straight to NS_GREEN, walk stays 0.
- Assert reset asynchronously (between clk edges) mid EW_YELLOW with cnt=1 -> outputs immediately ns=ew=100, state=5, walk=0, phase_done=0. After release, the first tick enters NS_GREEN.
- Force state=7 via hierarchical deposit -> next clk state=2 (ALLRED_A), cnt=0, both lamps red. The sequence then resumes normally.

Source files
------------

// File: rtl/tick_phase_sequencer.sv
// Tick-driven traffic-light phase sequencer: NS/EW green-yellow-allred cycle.
// Optional pedestrian walk phase is built when TICK_PHASE_PED_WALK_EN is defined.
module tick_phase_sequencer #(
  parameter int GREEN_TICKS  = 5,
  parameter int YELLOW_TICKS = 2,
  parameter int ALLRED_TICKS = 1,
  parameter int WALK_TICKS   = 3,
  parameter int CNT_W        = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       ped_req,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       walk,
  output logic [2:0] state,
  output logic       phase_done
);

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALLRED_A  = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALLRED_B  = 3'd5,
    PED_WALK  = 3'd6
  } phase_e;

  logic [2:0]       st;
  logic [2:0]       nxt;
  logic [CNT_W-1:0] cnt;
  logic             illegal;

  function automatic logic [CNT_W-1:0] last_cnt(input logic [2:0] s);
    case (s)
      NS_GREEN, EW_GREEN:   last_cnt = CNT_W'(GREEN_TICKS - 1);
      NS_YELLOW, EW_YELLOW: last_cnt = CNT_W'(YELLOW_TICKS - 1);
      ALLRED_A, ALLRED_B:   last_cnt = CNT_W'(ALLRED_TICKS - 1);
      PED_WALK:             last_cnt = CNT_W'(WALK_TICKS - 1);
      default:              last_cnt = '0;
    endcase
  endfunction

`ifdef TICK_PHASE_PED_WALK_EN
  logic ped_pend;

  assign illegal = (st == 3'd7);
  assign walk    = (st == PED_WALK);
`else
  logic unused_ped_req;

  assign unused_ped_req = ped_req;
  assign illegal        = (st >= 3'd6);
  assign walk           = 1'b0;
`endif

  always_comb begin
    nxt = ALLRED_A;
    case (st)
      NS_GREEN:  nxt = NS_YELLOW;
      NS_YELLOW: nxt = ALLRED_A;
      ALLRED_A:  nxt = EW_GREEN;
      EW_GREEN:  nxt = EW_YELLOW;
      EW_YELLOW: nxt = ALLRED_B;
`ifdef TICK_PHASE_PED_WALK_EN
      ALLRED_B:  nxt = ped_pend ? PED_WALK : NS_GREEN;
      PED_WALK:  nxt = NS_GREEN;
`else
      ALLRED_B:  nxt = NS_GREEN;
`endif
      default:   nxt = ALLRED_A;
    endcase
  end

  // Sequencing stage: counter, state and done pulse all change together
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st         <= ALLRED_B;
      cnt        <= '0;
      phase_done <= 1'b0;
`ifdef TICK_PHASE_PED_WALK_EN
      ped_pend   <= 1'b0;
`endif
    end else begin
      phase_done <= 1'b0;
`ifdef TICK_PHASE_PED_WALK_EN
      if (ped_req && st != PED_WALK) ped_pend <= 1'b1;
`endif
      if (illegal) begin
        st  <= ALLRED_A;
        cnt <= '0;
      end else if (tick) begin
        if (cnt == last_cnt(st)) begin
          st         <= nxt;
          cnt        <= '0;
          phase_done <= 1'b1;
`ifdef TICK_PHASE_PED_WALK_EN
          // Entering the walk consumes any request seen on this same clock
          if (nxt == PED_WALK) ped_pend <= 1'b0;
`endif
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  always_comb begin
    ns_light = 3'b100;
    ew_light = 3'b100;
    case (st)
      NS_GREEN:  ns_light = 3'b001;
      NS_YELLOW: ns_light = 3'b010;
      EW_GREEN:  ew_light = 3'b001;
      EW_YELLOW: ew_light = 3'b010;
      default: begin
        ns_light = 3'b100;
        ew_light = 3'b100;
      end
    endcase
  end

  assign state = st;

endmodule

// File: tb/tb_tick_phase_sequencer.sv
// Directed bench for tick_phase_sequencer; expectations follow the build's
// TICK_PHASE_PED_WALK_EN setting.
module tb_tick_phase_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       ped_req = 1'b0;
  logic [2:0] ns_light;
  logic [2:0] ew_light;
  logic       walk;
  logic [2:0] state;
  logic       phase_done;

  int         checks = 0;
  int         errors = 0;
  int         pulses = 0;
  logic [2:0] model_st = 3'd5;

`ifdef TICK_PHASE_PED_WALK_EN
  localparam bit PED_ON = 1'b1;
`else
  localparam bit PED_ON = 1'b0;
`endif

  tick_phase_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .ped_req    (ped_req),
    .ns_light   (ns_light),
    .ew_light   (ew_light),
    .walk       (walk),
    .state      (state),
    .phase_done (phase_done)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] exp_ns(input logic [2:0] s);
    case (s)
      3'd0:    exp_ns = 3'b001;
      3'd1:    exp_ns = 3'b010;
      default: exp_ns = 3'b100;
    endcase
  endfunction

  function automatic logic [2:0] exp_ew(input logic [2:0] s);
    case (s)
      3'd3:    exp_ew = 3'b001;
      3'd4:    exp_ew = 3'b010;
      default: exp_ew = 3'b100;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One tick period of three clocks, entered and left on a falling edge.
  task automatic step(input logic [2:0] exp);
    logic pd_exp;
    pd_exp   = (exp != model_st);
    model_st = exp;
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    if (phase_done === 1'b1) pulses++;
    chk("state", 8'(state), 8'(exp));
    chk("phase_done", 8'(phase_done), 8'(pd_exp));
    chk("ns_light", 8'(ns_light), 8'(exp_ns(exp)));
    chk("ew_light", 8'(ew_light), 8'(exp_ew(exp)));
    chk("walk", 8'(walk), 8'(PED_ON && exp == 3'd6));
    chk("excl", 8'(ns_light != 3'b100 && ew_light != 3'b100), 8'd0);
    @(negedge clk);
    chk("pd_low", 8'(phase_done), 8'd0);
    @(negedge clk);
  endtask

  task automatic step_n(input logic [2:0] exp, input int n);
    for (int i = 0; i < n; i++) step(exp);
  endtask

  task automatic pulse_ped();
    ped_req = 1'b1;
    @(negedge clk);
    ped_req = 1'b0;
    @(negedge clk);
  endtask

  // From NS_GREEN with cnt=0, one full 16-tick cycle back to NS_GREEN.
  task automatic run_cycle();
    step_n(3'd0, 4);
    step_n(3'd1, 2);
    step(3'd2);
    step_n(3'd3, 5);
    step_n(3'd4, 2);
    step(3'd5);
    step(3'd0);
  endtask

  logic [2:0] seq17 [17] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd3,
                              3'd3, 3'd3, 3'd3, 3'd3, 3'd4, 3'd4, 3'd5, 3'd0};

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_state", 8'(state), 8'd5);
    chk("rst_ns", 8'(ns_light), 8'h4);
    chk("rst_ew", 8'(ew_light), 8'h4);
    chk("rst_walk", 8'(walk), 8'd0);
    chk("rst_pd", 8'(phase_done), 8'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("rel_state", 8'(state), 8'd5);

    // Basic 17-tick sequence from reset
    pulses = 0;
    for (int i = 0; i < 17; i++) step(seq17[i]);
    chk("pulse_count", 8'(pulses), 8'd7);
    chk("cnt_after17", 8'(dut.cnt), 8'd0);

    // No ticks: everything holds
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("hold_state", 8'(state), 8'd0);
      chk("hold_pd", 8'(phase_done), 8'd0);
    end
    chk("hold_cnt", 8'(dut.cnt), 8'd0);

    // Pedestrian request during EW_GREEN
    step_n(3'd0, 4);
    step_n(3'd1, 2);
    step(3'd2);
    step(3'd3);
    pulse_ped();
    step_n(3'd3, 4);
    step_n(3'd4, 2);
    step(3'd5);
    if (PED_ON) begin
      step(3'd6);
      pulse_ped();
      step_n(3'd6, 2);
      step(3'd0);
    end else begin
      step(3'd0);
      pulse_ped();
    end
    run_cycle();

    // Asynchronous reset mid EW_YELLOW with cnt=1
    step_n(3'd0, 4);
    step_n(3'd1, 2);
    step(3'd2);
    step_n(3'd3, 5);
    step_n(3'd4, 2);
    chk("pre_rst_cnt", 8'(dut.cnt), 8'd1);
    #2 reset = 1'b1;
    #1;
    chk("arst_state", 8'(state), 8'd5);
    chk("arst_ns", 8'(ns_light), 8'h4);
    chk("arst_ew", 8'(ew_light), 8'h4);
    chk("arst_walk", 8'(walk), 8'd0);
    chk("arst_pd", 8'(phase_done), 8'd0);
    chk("arst_cnt", 8'(dut.cnt), 8'd0);
    @(negedge clk);
    reset = 1'b0;
    model_st = 3'd5;
    @(negedge clk);
    step(3'd0);

    // Illegal encoding 7 recovers to ALLRED_A
    force dut.st = 3'd7;
    #1;
    release dut.st;
    chk("ill_ns", 8'(ns_light), 8'h4);
    chk("ill_ew", 8'(ew_light), 8'h4);
    @(negedge clk);
    chk("rec_state", 8'(state), 8'd2);
    chk("rec_cnt", 8'(dut.cnt), 8'd0);
    chk("rec_pd", 8'(phase_done), 8'd0);
    chk("rec_ns", 8'(ns_light), 8'h4);
    model_st = 3'd2;
    step(3'd3);
    step_n(3'd3, 4);
    step_n(3'd4, 2);
    step(3'd5);
    step(3'd0);

    // Encoding 6 is illegal only when the walk phase is not built
    if (!PED_ON) begin
      force dut.st = 3'd6;
      #1;
      release dut.st;
      @(negedge clk);
      chk("rec6_state", 8'(state), 8'd2);
      chk("rec6_pd", 8'(phase_done), 8'd0);
      chk("rec6_walk", 8'(walk), 8'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
